// File: rtl/counter_stream_checker.sv
// Self-checking monitor for a WIDTH-bit enable-gated up-counter: predicts each step, counts mismatches and wraps.
// Optional build macro CHECKER_STICKY_FAULT_EN: a mismatch parks the checker in FAULT until reset.
module counter_stream_checker #(
    parameter int WIDTH  = 4,
    parameter int ERR_W  = 8,
    parameter int WRAP_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [WIDTH-1:0]  counter_in,
    output logic              locked,
    output logic              err_pulse,
    output logic [ERR_W-1:0]  error_count,
    output logic [WRAP_W-1:0] wrap_count,
    output logic [WIDTH-1:0]  last_expected,
    output logic [WIDTH-1:0]  last_actual
);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'b00,
        ST_TRACK = 2'b01
`ifdef CHECKER_STICKY_FAULT_EN
        ,
        ST_FAULT = 2'b10
`endif
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;

    logic [WIDTH-1:0]   prev_cnt_r;
    logic               prev_en_r;
    logic [WIDTH-1:0]   exp_s;
    logic               mismatch_s;

    logic               capture_s;
    logic               mismatch_hit_s;
    logic               wrap_hit_s;

    logic               locked_r;
    logic               err_pulse_r;
    logic [ERR_W-1:0]   error_count_r;
    logic [WRAP_W-1:0]  wrap_count_r;
    logic [WIDTH-1:0]   last_expected_r;
    logic [WIDTH-1:0]   last_actual_r;

    function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
        logic [ERR_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + ERR_W'(1'b1);
        end
        return r;
    endfunction

    function automatic logic [WRAP_W-1:0] sat_inc_wrap(input logic [WRAP_W-1:0] v);
        logic [WRAP_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + WRAP_W'(1'b1);
        end
        return r;
    endfunction

    // Prediction uses the registered enable, so an enable toggling every cycle is tracked exactly.
    assign exp_s      = prev_en_r ? (prev_cnt_r + WIDTH'(1'b1)) : prev_cnt_r;
    // Case inequality makes X/Z on the observed value count as a mismatch in simulation.
    assign mismatch_s = (counter_in !== exp_s);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_SYNC;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode and per-edge action strobes.
    always_comb begin
        state_nxt_s    = state_r;
        capture_s      = 1'b0;
        mismatch_hit_s = 1'b0;
        wrap_hit_s     = 1'b0;
        case (state_r)
            ST_SYNC: begin
                capture_s   = 1'b1;
                state_nxt_s = ST_TRACK;
            end
            ST_TRACK: begin
                if (mismatch_s) begin
                    mismatch_hit_s = 1'b1;
`ifdef CHECKER_STICKY_FAULT_EN
                    state_nxt_s    = ST_FAULT;
`else
                    state_nxt_s    = ST_SYNC;
`endif
                end else begin
                    capture_s  = 1'b1;
                    wrap_hit_s = prev_en_r & (&prev_cnt_r);
                end
            end
`ifdef CHECKER_STICKY_FAULT_EN
            ST_FAULT: begin
                state_nxt_s = ST_FAULT;
            end
`endif
            default: begin
                state_nxt_s = ST_SYNC;
            end
        endcase
    end

    // History, counters and registered status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_cnt_r      <= {WIDTH{1'b0}};
            prev_en_r       <= 1'b0;
            locked_r        <= 1'b0;
            err_pulse_r     <= 1'b0;
            error_count_r   <= {ERR_W{1'b0}};
            wrap_count_r    <= {WRAP_W{1'b0}};
            last_expected_r <= {WIDTH{1'b0}};
            last_actual_r   <= {WIDTH{1'b0}};
        end else begin
            locked_r    <= (state_nxt_s == ST_TRACK);
            err_pulse_r <= mismatch_hit_s;
            if (capture_s) begin
                prev_cnt_r <= counter_in;
                prev_en_r  <= enable;
            end
            if (mismatch_hit_s) begin
                error_count_r   <= sat_inc_err(error_count_r);
                last_expected_r <= exp_s;
                last_actual_r   <= counter_in;
            end
            if (wrap_hit_s) begin
                wrap_count_r <= sat_inc_wrap(wrap_count_r);
            end
        end
    end

    assign locked        = locked_r;
    assign err_pulse     = err_pulse_r;
    assign error_count   = error_count_r;
    assign wrap_count    = wrap_count_r;
    assign last_expected = last_expected_r;
    assign last_actual   = last_actual_r;

endmodule

// File: tb/tb_counter_stream_checker.sv
// Directed bench for counter_stream_checker built with 2-bit error and wrap counters to reach saturation quickly.
module tb_counter_stream_checker;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] counter_in = 4'd0;
    logic       locked;
    logic       err_pulse;
    logic [1:0] error_count;
    logic [1:0] wrap_count;
    logic [3:0] last_expected;
    logic [3:0] last_actual;

    int         checks = 0;
    int         failures = 0;
    logic [3:0] cnt = 4'd0;

    counter_stream_checker #(.WIDTH(4), .ERR_W(2), .WRAP_W(2)) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .counter_in    (counter_in),
        .locked        (locked),
        .err_pulse     (err_pulse),
        .error_count   (error_count),
        .wrap_count    (wrap_count),
        .last_expected (last_expected),
        .last_actual   (last_actual)
    );

    always #5 clock = ~clock;

    // One cycle of a correct counter: present cnt, then advance the reference counter.
    task automatic drive_good(input logic en);
        enable     = en;
        counter_in = cnt;
        @(posedge clock);
        #1;
        cnt = en ? cnt + 4'd1 : cnt;
    endtask

    // One cycle with a corrupted value; the reference counter continues from the corrupted value.
    task automatic drive_bad(input logic en, input logic [3:0] bad);
        enable     = en;
        counter_in = bad;
        @(posedge clock);
        #1;
        cnt = en ? bad + 4'd1 : bad;
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b1;
        repeat (n) drive_good(1'b0);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        cnt = 4'd0;
        apply_reset(3);
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%0b exp=0", locked); end
        checks++; if (err_pulse !== 1'b0) begin failures++; $display("FAIL reset_err_pulse got=%0b exp=0", err_pulse); end
        checks++; if (error_count !== 2'd0) begin failures++; $display("FAIL reset_error_count got=%0d exp=0", error_count); end
        checks++; if (wrap_count !== 2'd0) begin failures++; $display("FAIL reset_wrap_count got=%0d exp=0", wrap_count); end
        checks++; if (last_expected !== 4'd0) begin failures++; $display("FAIL reset_last_expected got=%0d exp=0", last_expected); end
        checks++; if (last_actual !== 4'd0) begin failures++; $display("FAIL reset_last_actual got=%0d exp=0", last_actual); end
    endtask

    task automatic test_clean_run;
        for (int i = 0; i < 2; i++) begin
            drive_good(1'b0);
            checks++; if (locked !== 1'b1) begin failures++; $display("FAIL clean_idle_locked i=%0d got=%0b exp=1", i, locked); end
            checks++; if (error_count !== 2'd0) begin failures++; $display("FAIL clean_idle_errors i=%0d got=%0d exp=0", i, error_count); end
        end
        for (int i = 0; i < 20; i++) begin
            drive_good(1'b1);
            checks++; if (locked !== 1'b1) begin failures++; $display("FAIL clean_locked i=%0d got=%0b exp=1", i, locked); end
            checks++; if (error_count !== 2'd0) begin failures++; $display("FAIL clean_errors i=%0d got=%0d exp=0", i, error_count); end
            checks++; if (wrap_count !== ((i >= 16) ? 2'd1 : 2'd0)) begin failures++; $display("FAIL clean_wrap i=%0d got=%0d exp=%0d", i, wrap_count, (i >= 16) ? 1 : 0); end
        end
    endtask

    task automatic test_injected_fault;
        drive_good(1'b1);
        drive_bad(1'b1, 4'h7);
        checks++; if (err_pulse !== 1'b1) begin failures++; $display("FAIL inj_err_pulse got=%0b exp=1", err_pulse); end
        checks++; if (error_count !== 2'd1) begin failures++; $display("FAIL inj_error_count got=%0d exp=1", error_count); end
        checks++; if (last_expected !== 4'h5) begin failures++; $display("FAIL inj_last_expected got=%0h exp=5", last_expected); end
        checks++; if (last_actual !== 4'h7) begin failures++; $display("FAIL inj_last_actual got=%0h exp=7", last_actual); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL inj_locked_drop got=%0b exp=0", locked); end
        drive_good(1'b1);
        checks++; if (err_pulse !== 1'b0) begin failures++; $display("FAIL inj_pulse_width got=%0b exp=0", err_pulse); end
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL inj_relock got=%0b exp=1", locked); end
        for (int i = 0; i < 5; i++) begin
            drive_good(1'b1);
            checks++; if (error_count !== 2'd1 || err_pulse !== 1'b0) begin failures++; $display("FAIL inj_resume i=%0d got=%0d/%0b exp=1/0", i, error_count, err_pulse); end
        end
    endtask

    task automatic test_enable_toggle;
        cnt = 4'd0;
        apply_reset(1);
        for (int i = 0; i < 32; i++) begin
            drive_good((i % 2) == 0);
            checks++; if (locked !== 1'b1) begin failures++; $display("FAIL tog_locked i=%0d got=%0b exp=1", i, locked); end
            checks++; if (error_count !== 2'd0) begin failures++; $display("FAIL tog_errors i=%0d got=%0d exp=0", i, error_count); end
            checks++; if (wrap_count !== ((i == 31) ? 2'd1 : 2'd0)) begin failures++; $display("FAIL tog_wrap i=%0d got=%0d exp=%0d", i, wrap_count, (i == 31) ? 1 : 0); end
        end
    endtask

    task automatic test_saturation;
        logic [1:0] exp_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        logic [3:0] exp_v;
        int         pulses = 0;
        cnt = 4'd0;
        apply_reset(1);
        drive_good(1'b1);
        for (int k = 0; k < 5; k++) begin
            exp_v = cnt;
            drive_bad(1'b1, exp_v + 4'd8);
            if (err_pulse === 1'b1) pulses++;
            checks++; if (error_count !== exp_seq[k]) begin failures++; $display("FAIL sat_count k=%0d got=%0d exp=%0d", k, error_count, exp_seq[k]); end
            checks++; if (last_expected !== exp_v || last_actual !== exp_v + 4'd8) begin failures++; $display("FAIL sat_capture k=%0d got=%0h/%0h exp=%0h/%0h", k, last_expected, last_actual, exp_v, exp_v + 4'd8); end
            drive_good(1'b1);
            if (err_pulse === 1'b1) pulses++;
            checks++; if (locked !== 1'b1) begin failures++; $display("FAIL sat_relock k=%0d got=%0b exp=1", k, locked); end
            drive_good(1'b1);
            if (err_pulse === 1'b1) pulses++;
        end
        checks++; if (pulses != 5) begin failures++; $display("FAIL sat_pulses got=%0d exp=5", pulses); end
    endtask

    task automatic test_reset_mid_run;
        cnt = 4'd0;
        apply_reset(1);
        drive_good(1'b1);
        repeat (48) drive_good(1'b1);
        checks++; if (wrap_count !== 2'd3) begin failures++; $display("FAIL mid_wrap3 got=%0d exp=3", wrap_count); end
        repeat (16) drive_good(1'b1);
        checks++; if (wrap_count !== 2'd3) begin failures++; $display("FAIL mid_wrap_sat got=%0d exp=3", wrap_count); end
        drive_bad(1'b1, cnt + 4'd8);
        drive_good(1'b1);
        drive_good(1'b1);
        drive_bad(1'b1, cnt + 4'd8);
        checks++; if (error_count !== 2'd2) begin failures++; $display("FAIL mid_errors got=%0d exp=2", error_count); end
        apply_reset(1);
        checks++; if ({locked, err_pulse, error_count, wrap_count, last_expected, last_actual} !== 14'd0) begin
            failures++; $display("FAIL mid_reset_outputs got=%0b/%0b/%0d/%0d/%0h/%0h exp=all 0", locked, err_pulse, error_count, wrap_count, last_expected, last_actual);
        end
        drive_good(1'b1);
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL mid_relock got=%0b exp=1", locked); end
    endtask

`ifdef CHECKER_STICKY_FAULT_EN
    task automatic test_sticky_fault;
        cnt = 4'd0;
        apply_reset(1);
        drive_good(1'b1);
        drive_good(1'b1);
        drive_bad(1'b1, cnt + 4'd8);
        checks++; if (err_pulse !== 1'b1) begin failures++; $display("FAIL sticky_pulse got=%0b exp=1", err_pulse); end
        for (int k = 0; k < 2; k++) begin
            drive_good(1'b1);
            drive_bad(1'b1, cnt + 4'd8);
            checks++; if (err_pulse !== 1'b0 || locked !== 1'b0) begin failures++; $display("FAIL sticky_hold k=%0d got=%0b/%0b exp=0/0", k, err_pulse, locked); end
        end
        checks++; if (error_count !== 2'd1) begin failures++; $display("FAIL sticky_count got=%0d exp=1", error_count); end
        apply_reset(1);
        drive_good(1'b1);
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL sticky_relock got=%0b exp=1", locked); end
    endtask
`endif

    initial begin
        test_reset;
        test_clean_run;
`ifdef CHECKER_STICKY_FAULT_EN
        test_sticky_fault;
`else
        test_injected_fault;
        test_enable_toggle;
        test_saturation;
        test_reset_mid_run;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
